// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, load-sequence states and flag bit positions for alu_seq_top
package alu_pkg;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_SRA = 6'b000011;

    typedef enum logic [1:0] {
        WAIT_A  = 2'd0,
        WAIT_B  = 2'd1,
        WAIT_OP = 2'd2,
        RESULT  = 2'd3
    } state_t;

    // FLAGS is packed {N,Z,C,V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU {a,b,op} -> result; ALU_FLAGS_EN adds {N,Z,C,V}
module alu_core
    import alu_pkg::*;
#(
    parameter int SIZEDATA = 8,
    parameter int SIZEOP   = 6
) (
    input  logic [SIZEDATA-1:0] a,
    input  logic [SIZEDATA-1:0] b,
    input  logic [SIZEOP-1:0]   op,
    output logic [SIZEDATA-1:0] result
`ifdef ALU_FLAGS_EN
    ,
    output logic [3:0]          flags
`endif
);

    localparam logic [SIZEDATA:0] WIDTH = (SIZEDATA+1)'(SIZEDATA);

    // Shift distances at or beyond the word width saturate rather than wrap
    logic                       shift_over;
    logic signed [SIZEDATA-1:0] sra_val;

    assign shift_over = ({1'b0, b} >= WIDTH);
    assign sra_val    = $signed(a) >>> b;

    always_comb begin
        result = '0;
        case (op)
            SIZEOP'(OP_ADD): result = a + b;
            SIZEOP'(OP_SUB): result = a - b;
            SIZEOP'(OP_AND): result = a & b;
            SIZEOP'(OP_OR):  result = a | b;
            SIZEOP'(OP_XOR): result = a ^ b;
            SIZEOP'(OP_NOR): result = ~(a | b);
            SIZEOP'(OP_SRL): result = shift_over ? '0 : (a >> b);
            SIZEOP'(OP_SRA): result = shift_over ? {SIZEDATA{a[SIZEDATA-1]}} : sra_val;
            default:         result = '0;
        endcase
    end

`ifdef ALU_FLAGS_EN
    logic [SIZEDATA:0] sum_ext;

    assign sum_ext = {1'b0, a} + {1'b0, b};

    always_comb begin
        flags         = '0;
        flags[FLAG_N] = result[SIZEDATA-1];
        flags[FLAG_Z] = (result == '0);
        if (op == SIZEOP'(OP_ADD)) begin
            flags[FLAG_C] = sum_ext[SIZEDATA];
            flags[FLAG_V] = (a[SIZEDATA-1] == b[SIZEDATA-1]) && (result[SIZEDATA-1] != a[SIZEDATA-1]);
        end else if (op == SIZEOP'(OP_SUB)) begin
            // C reports a borrow, i.e. a < b unsigned
            flags[FLAG_C] = (a < b);
            flags[FLAG_V] = (a[SIZEDATA-1] != b[SIZEDATA-1]) && (result[SIZEDATA-1] != a[SIZEDATA-1]);
        end
    end
`endif

endmodule

// File: rtl/alu_seq_top.sv
// rtl/alu_seq_top.sv - button-sequenced ALU front-end (sync, edge detect, load FSM); ALU_FLAGS_EN adds FLAGS
module alu_seq_top
    import alu_pkg::*;
#(
    parameter int SIZEDATA    = 8,
    parameter int SIZEOP      = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic [SIZEDATA-1:0] SWITCHES,
    input  logic [2:0]          BUTTONS,
    output logic [SIZEDATA-1:0] LEDS,
    output logic                VALID,
    output logic [1:0]          STATE
`ifdef ALU_FLAGS_EN
    ,
    output logic [3:0]          FLAGS
`endif
);

    generate
        if (SIZEDATA < SIZEOP) begin : g_bad_size
            $error("alu_seq_top: SIZEDATA must be >= SIZEOP");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("alu_seq_top: SYNC_STAGES must be >= 2");
        end
    endgenerate

    logic [2:0]          sync_q [SYNC_STAGES];
    logic [2:0]          btn_prev;
    logic [2:0]          press;
    state_t              state_q, state_d;
    logic                load_a, load_b, load_op, load_res;
    logic [SIZEDATA-1:0] a_q, b_q;
    logic [SIZEOP-1:0]   op_q;
    logic [SIZEDATA-1:0] core_result;
`ifdef ALU_FLAGS_EN
    logic [3:0]          core_flags;
`endif

    // Reset clears the chains, so a button held through reset release reads as a fresh press
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            btn_prev <= '0;
        end else begin
            sync_q[0] <= BUTTONS;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            btn_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign press = sync_q[SYNC_STAGES-1] & ~btn_prev;

    always_ff @(posedge CLK) begin
        if (!RESET_N) state_q <= WAIT_A;
        else          state_q <= state_d;
    end

    // Only a lone press pulse is honoured; simultaneous pulses are dropped as ambiguous
    always_comb begin
        state_d  = state_q;
        load_a   = 1'b0;
        load_b   = 1'b0;
        load_op  = 1'b0;
        load_res = 1'b0;
        case (state_q)
            WAIT_A: if (press == 3'b001) begin
                load_a  = 1'b1;
                state_d = WAIT_B;
            end
            WAIT_B: if (press == 3'b010) begin
                load_b  = 1'b1;
                state_d = WAIT_OP;
            end
            WAIT_OP: if (press == 3'b100) begin
                load_op = 1'b1;
                state_d = RESULT;
            end
            RESULT: begin
                if (press == 3'b001) begin
                    load_a  = 1'b1;
                    state_d = WAIT_B;
                end else if (press == 3'b100) begin
                    load_op = 1'b1;
                end else if (!VALID) begin
                    load_res = 1'b1;
                end
            end
            default: state_d = WAIT_A;
        endcase
    end

    alu_core #(
        .SIZEDATA (SIZEDATA),
        .SIZEOP   (SIZEOP)
    ) u_core (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (core_result)
`ifdef ALU_FLAGS_EN
        ,
        .flags  (core_flags)
`endif
    );

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            LEDS  <= '0;
            VALID <= 1'b0;
`ifdef ALU_FLAGS_EN
            FLAGS <= '0;
`endif
        end else begin
            if (load_a)  a_q  <= SWITCHES;
            if (load_b)  b_q  <= SWITCHES;
            if (load_op) op_q <= SWITCHES[SIZEOP-1:0];
            // LEDS keep the last result while a new operand set is being entered
            if (load_res) begin
                LEDS  <= core_result;
                VALID <= 1'b1;
`ifdef ALU_FLAGS_EN
                FLAGS <= core_flags;
`endif
            end else if (load_a || load_op) begin
                VALID <= 1'b0;
            end
        end
    end

    assign STATE = state_q;

endmodule

// File: tb/tb_alu_seq_top.sv
// tb/tb_alu_seq_top.sv - directed bench for alu_seq_top with a cycle-level reference model
module tb_alu_seq_top;

    localparam int SYNC_STAGES = 2;

    logic       CLK;
    logic       RESET_N;
    logic [7:0] SWITCHES;
    logic [2:0] BUTTONS;
    logic [7:0] LEDS;
    logic       VALID;
    logic [1:0] STATE;
`ifdef ALU_FLAGS_EN
    logic [3:0] FLAGS;
`endif

    alu_seq_top #(
        .SIZEDATA    (8),
        .SIZEOP      (6),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .SWITCHES (SWITCHES),
        .BUTTONS  (BUTTONS),
        .LEDS     (LEDS),
        .VALID    (VALID),
        .STATE    (STATE)
`ifdef ALU_FLAGS_EN
        ,
        .FLAGS    (FLAGS)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;
    int printed     = 0;
    bit run_chk     = 0;

    // Reference ALU on plain integers: returns {N,Z,C,V,result[7:0]}
    function automatic logic [11:0] alu_ref(input int a, input int b, input int op);
        int r, sa, sb, s;
        bit n, z, c, v;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        c = 0;
        v = 0;
        case (op)
            32: begin r = a + b; c = (r > 255); s = sa + sb; v = (s > 127 || s < -128); end
            34: begin r = a - b; c = (a < b);   s = sa - sb; v = (s > 127 || s < -128); end
            36: r = a & b;
            37: r = a | b;
            38: r = a ^ b;
            39: r = ~(a | b);
            2:  r = (b >= 8) ? 0 : (a >> b);
            3:  r = (b >= 8) ? ((sa < 0) ? 255 : 0) : (sa >>> b);
            default: r = 0;
        endcase
        r = r & 255;
        n = (r >= 128);
        z = (r == 0);
        return {n, z, c, v, 8'(r)};
    endfunction

    // Model: a button level sampled at edge k produces a press at edge k+SYNC_STAGES
    logic [2:0] h [0:SYNC_STAGES];
    logic [7:0] m_a, m_b, m_leds;
    logic [5:0] m_op;
    logic [3:0] m_flags;
    int         m_state;
    bit         m_valid, m_pend;

    always @(posedge CLK) begin
        logic [2:0] pr;
        int ev;
        if (!RESET_N) begin
            for (int j = 0; j <= SYNC_STAGES; j++) h[j] = 3'b000;
            m_a = 0; m_b = 0; m_op = 0; m_leds = 0; m_flags = 0;
            m_state = 0; m_valid = 0; m_pend = 0;
        end else begin
            pr = h[SYNC_STAGES-1] & ~h[SYNC_STAGES];
            for (int j = SYNC_STAGES; j > 0; j--) h[j] = h[j-1];
            h[0] = BUTTONS;
            ev = (pr == 3'b001) ? 0 : (pr == 3'b010) ? 1 : (pr == 3'b100) ? 2 : -1;
            if (m_state == 0 && ev == 0) begin
                m_a = SWITCHES; m_state = 1;
            end else if (m_state == 1 && ev == 1) begin
                m_b = SWITCHES; m_state = 2;
            end else if (m_state == 2 && ev == 2) begin
                m_op = SWITCHES[5:0]; m_state = 3; m_pend = 1;
            end else if (m_state == 3 && ev == 0) begin
                m_a = SWITCHES; m_valid = 0; m_pend = 0; m_state = 1;
            end else if (m_state == 3 && ev == 2) begin
                m_op = SWITCHES[5:0]; m_valid = 0; m_pend = 1;
            end else if (m_pend) begin
                {m_flags, m_leds} = alu_ref(int'(m_a), int'(m_b), int'(m_op));
                m_valid = 1;
                m_pend = 0;
            end
        end
    end

    always @(negedge CLK) begin
        bit bad;
        if (run_chk) begin
            vectors++;
            bad = (LEDS !== m_leds) || (VALID !== m_valid) || (STATE !== 2'(m_state));
`ifdef ALU_FLAGS_EN
            bad = bad || (FLAGS !== m_flags);
`endif
            if (bad) begin
                miscompares++;
                if (printed < 20) begin
                    printed++;
                    $display("FAIL cycle_model t=%0t got leds=%h valid=%b state=%0d expected leds=%h valid=%b state=%0d",
                             $time, LEDS, VALID, STATE, m_leds, m_valid, m_state);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_flags(input string name, input int exp);
`ifdef ALU_FLAGS_EN
        chk(name, int'(FLAGS), exp);
`endif
    endtask

    task automatic do_press(input int idx, input logic [7:0] sw);
        @(negedge CLK);
        SWITCHES = sw;
        BUTTONS = 3'b000;
        BUTTONS[idx] = 1'b1;
        repeat (3) @(negedge CLK);
        BUTTONS = 3'b000;
        repeat (4) @(negedge CLK);
    endtask

    task automatic apply_reset(input int cycles);
        @(negedge CLK);
        RESET_N = 1'b0;
        repeat (cycles) @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    initial begin
        int k, lows;
        RESET_N = 1'b0;
        SWITCHES = 8'h00;
        BUTTONS = 3'b000;
        repeat (3) @(negedge CLK);
        run_chk = 1;
        RESET_N = 1'b1;
        @(negedge CLK);
        chk("reset_leds", int'(LEDS), 0);
        chk("reset_valid", int'(VALID), 0);
        chk("reset_state", int'(STATE), 0);
        chk_flags("reset_flags", 0);

        // 0x7F + 0x01 with VALID latency measured from the first sampling edge
        do_press(0, 8'h7F);
        do_press(1, 8'h01);
        @(negedge CLK);
        SWITCHES = 8'h20;
        BUTTONS = 3'b100;
        for (k = 1; k <= 10; k++) begin
            @(posedge CLK);
            #1;
            if (VALID) break;
        end
        chk("add_valid_latency", k, 4);
        @(negedge CLK);
        BUTTONS = 3'b000;
        repeat (3) @(negedge CLK);
        chk("add_leds", int'(LEDS), 8'h80);
        chk("add_valid", int'(VALID), 1);
        chk("add_state", int'(STATE), 3);
        chk_flags("add_flags", 4'b1001);
        chk("model_add_leds", int'(m_leds), 8'h80);

        // Reload A in RESULT: LEDS hold, VALID drops
        do_press(0, 8'h05);
        chk("reload_a_state", int'(STATE), 1);
        chk("reload_a_leds_hold", int'(LEDS), 8'h80);
        chk("reload_a_valid", int'(VALID), 0);
        do_press(1, 8'h07);
        do_press(2, 8'h22);
        chk("sub_leds", int'(LEDS), 8'hFE);
        chk_flags("sub_flags", 4'b1010);

        @(negedge CLK);
        SWITCHES = 8'h24;
        BUTTONS = 3'b100;
        lows = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (!VALID) lows++;
        end
        BUTTONS = 3'b000;
        chk("and_valid_low_cycles", lows, 1);
        chk("and_leds", int'(LEDS), 8'h05);
        chk_flags("and_flags", 4'b0000);

        // Shifts and NOR
        do_press(0, 8'h80);
        do_press(1, 8'h03);
        do_press(2, 8'h03);
        chk("sra3_leds", int'(LEDS), 8'hF0);
        do_press(0, 8'h80);
        do_press(1, 8'h09);
        do_press(2, 8'h03);
        chk("sra9_leds", int'(LEDS), 8'hFF);
        do_press(2, 8'h02);
        chk("srl9_leds", int'(LEDS), 8'h00);
        chk_flags("srl9_flags", 4'b0100);
        do_press(0, 8'hF0);
        do_press(1, 8'h0F);
        do_press(2, 8'h27);
        chk("nor_leds", int'(LEDS), 8'h00);
        chk_flags("nor_flags", 4'b0100);

        // Unknown opcode still produces a valid zero result
        do_press(2, 8'h3F);
        chk("unk_leds", int'(LEDS), 8'h00);
        chk("unk_valid", int'(VALID), 1);
        chk_flags("unk_flags", 4'b0100);

        // Build a non-zero result, then reset while in WAIT_OP
        do_press(0, 8'h11);
        do_press(1, 8'h22);
        do_press(2, 8'h20);
        chk("add33_leds", int'(LEDS), 8'h33);
        do_press(0, 8'h44);
        chk("reload_hold_leds", int'(LEDS), 8'h33);
        do_press(1, 8'h01);
        chk("wait_op_state", int'(STATE), 2);
        apply_reset(1);
        @(negedge CLK);
        chk("midreset_leds", int'(LEDS), 0);
        chk("midreset_valid", int'(VALID), 0);
        chk("midreset_state", int'(STATE), 0);

        // Out-of-order and simultaneous presses in WAIT_A
        do_press(1, 8'h12);
        chk("wait_a_btn1_state", int'(STATE), 0);
        do_press(2, 8'h20);
        chk("wait_a_btn2_state", int'(STATE), 0);
        @(negedge CLK);
        SWITCHES = 8'h33;
        BUTTONS = 3'b011;
        repeat (4) @(negedge CLK);
        BUTTONS = 3'b000;
        repeat (4) @(negedge CLK);
        chk("wait_a_both_state", int'(STATE), 0);

        // Long hold loads A exactly once
        @(negedge CLK);
        SWITCHES = 8'h5A;
        BUTTONS = 3'b001;
        repeat (10) @(negedge CLK);
        SWITCHES = 8'hA5;
        repeat (10) @(negedge CLK);
        BUTTONS = 3'b000;
        repeat (3) @(negedge CLK);
        chk("hold_state", int'(STATE), 1);
        do_press(1, 8'h01);
        do_press(2, 8'h20);
        chk("hold_add_leds", int'(LEDS), 8'h5B);

        // Button held across reset release counts as one press
        @(negedge CLK);
        RESET_N = 1'b0;
        SWITCHES = 8'h10;
        BUTTONS = 3'b001;
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        repeat (6) @(negedge CLK);
        BUTTONS = 3'b000;
        @(negedge CLK);
        chk("held_reset_state", int'(STATE), 1);
        do_press(1, 8'h10);
        do_press(2, 8'h20);
        chk("held_reset_leds", int'(LEDS), 8'h20);

        run_chk = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
